stage_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory-access and writeback one instruction at a time.
- Drives the execute stage's pipeline-control input, the memory-stage strobe and the writeback/PC write enables.
- Sits between the instruction/data memory ready signals and the stage enables; also provides halt and bus-error handling and a retired-instruction counter.

---
 rtl/stage_sequencer.sv | 109 ++++++++++
 tb/tb_stage_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MA/WB sequencer with halt, bus-error timeout and retire counter; optional cycle counter under STAGE_SEQ_CYCLE_COUNT_EN
module stage_sequencer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        dec_mem_op,
  input  logic        dec_rd_we,
  input  logic        halt_req,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_we,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] instret,
  output logic [63:0] cycle_count
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MA, S_WB, S_HALT} state_t;
  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);
  state_t state_q, state_d;
  logic [15:0] wait_q, wait_d, wait_inc;
  logic [31:0] instret_q, instret_d;
  logic halt_q, halt_d, err_q, err_d, mem_op_q, mem_op_d, rd_we_q, rd_we_d;
  logic wait_ready;
  assign wait_inc = wait_q + 16'd1;
  assign wait_ready = state_q == S_IF ? imem_ready : dmem_ready;
  // next state, wait timeout, flag latching and retire count
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    halt_d = halt_q | halt_req;
    err_d = err_q;
    mem_op_d = mem_op_q;
    rd_we_d = rd_we_q;
    instret_d = instret_q;
    case (state_q)
      S_IF, S_MA: begin
        if (wait_ready) begin
          wait_d = '0;
          state_d = state_q == S_IF ? S_ID : S_WB;
        end else if (wait_inc == LIMIT) begin
          wait_d = wait_inc;
          err_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_ID: begin
        mem_op_d = dec_mem_op;
        rd_we_d = dec_rd_we;
        state_d = S_EX;
      end
      S_EX: state_d = mem_op_q ? S_MA : S_WB;
      S_WB: begin
        instret_d = instret_q + 32'd1;
        state_d = halt_q | halt_req ? S_HALT : S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end
  // state and flag registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IF;
      wait_q <= '0;
      halt_q <= 1'b0;
      err_q <= 1'b0;
      mem_op_q <= 1'b0;
      rd_we_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      halt_q <= halt_d;
      err_q <= err_d;
      mem_op_q <= mem_op_d;
      rd_we_q <= rd_we_d;
      instret_q <= instret_d;
    end
  end
  assign fetch_en = state_q == S_IF;
  assign decode_en = state_q == S_ID;
  assign exec_en = state_q == S_EX;
  assign mem_en = state_q == S_MA;
  assign wb_en = state_q == S_WB && rd_we_q;
  assign pc_we = state_q == S_WB;
  assign halted = state_q == S_HALT;
  assign bus_err = err_q;
  assign instret = instret_q;
`ifdef STAGE_SEQ_CYCLE_COUNT_EN
  logic [63:0] cyc_q, cyc_d;
  assign cyc_d = state_q == S_HALT ? cyc_q : cyc_q + 64'd1;
  // free-running cycle counter, frozen while halted
  always_ff @(posedge clk) begin
    if (!rst) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end
  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: per-instruction reference model of the stage sequencer with randomized waits and decode inputs
module tb_stage_sequencer;
  localparam int WL = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, dec_mem_op = 1'b0, dec_rd_we = 1'b0, halt_req = 1'b0;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, halted, bus_err;
  logic [31:0] instret;
  logic [63:0] cycle_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_instret = '0;
  logic [63:0] m_cc = '0;
  bit m_halt = 1'b0;

  stage_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_mem_op(dec_mem_op), .dec_rd_we(dec_rd_we), .halt_req(halt_req),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
    .wb_en(wb_en), .pc_we(pc_we), .halted(halted), .bus_err(bus_err),
    .instret(instret), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic [7:0] en);
    chk({tag, ".outs"}, {56'd0, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, halted, bus_err}, {56'd0, en});
    chk({tag, ".instret"}, {32'd0, instret}, {32'd0, m_instret});
`ifdef STAGE_SEQ_CYCLE_COUNT_EN
    chk({tag, ".cycles"}, cycle_count, m_cc);
`else
    chk({tag, ".cycles"}, cycle_count, 64'd0);
`endif
  endtask

  task automatic tick();
    if (!m_halt) m_cc++;
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    dec_mem_op = 1'($urandom);
    dec_rd_we = 1'($urandom);
  endtask

  task automatic do_reset();
    noise();
    halt_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_cc = '0;
    m_instret = '0;
    m_halt = 1'b0;
    chk_cycle("reset", 8'b1000_0000);
  endtask

  task automatic run_instr(input int d, input bit m, input int k, input bit r, input bit h_ex, input bit h_wb);
    for (int i = 0; i < d; i++) begin
      noise(); imem_ready = 1'b0;
      chk_cycle("if_wait", 8'b1000_0000); tick();
    end
    noise(); imem_ready = 1'b1;
    chk_cycle("if", 8'b1000_0000); tick();
    noise(); dec_mem_op = m; dec_rd_we = r;
    chk_cycle("id", 8'b0100_0000); tick();
    noise(); halt_req = h_ex;
    chk_cycle("ex", 8'b0010_0000); tick();
    halt_req = 1'b0;
    if (m) begin
      for (int i = 0; i < k; i++) begin
        noise(); dmem_ready = 1'b0;
        chk_cycle("ma_wait", 8'b0001_0000); tick();
      end
      noise(); dmem_ready = 1'b1;
      chk_cycle("ma", 8'b0001_0000); tick();
    end
    noise(); halt_req = h_wb;
    chk_cycle("wb", {4'b0000, r, 1'b1, 2'b00}); tick();
    halt_req = 1'b0;
    m_instret = m_instret + 32'd1;
    if (h_ex || h_wb) m_halt = 1'b1;
  endtask

  task automatic stay_halted(input string tag, input int n, input bit err);
    for (int i = 0; i < n; i++) begin
      noise();
      chk_cycle(tag, {6'b000000, 1'b1, err}); tick();
    end
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1, 0, 0);
    chk("instret_after_12", {32'd0, instret}, 64'd3);
    run_instr(0, 1, 3, 1, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, WL - 1), 1'($urandom), $urandom_range(0, WL - 1), 1'($urandom), 0, 0);
    run_instr(1, 0, 0, 1, 1, 0);
    stay_halted("halt_ex", 6, 1'b0);
    do_reset();
    run_instr(0, 1, 1, 0, 0, 0);
    run_instr(2, 0, 0, 1, 0, 1);
    stay_halted("halt_wb", 4, 1'b0);
    do_reset();
    for (int i = 0; i < WL - 1; i++) begin
      imem_ready = 1'b0;
      chk_cycle("to_if_wait", 8'b1000_0000); tick();
    end
    imem_ready = 1'b0; halt_req = 1'b1;
    chk_cycle("to_if_last", 8'b1000_0000); tick();
    halt_req = 1'b0; m_halt = 1'b1;
    stay_halted("to_if", 5, 1'b1);
    do_reset();
    run_instr(0, 0, 0, 1, 0, 0);
    imem_ready = 1'b1;
    chk_cycle("to_ma_if", 8'b1000_0000); tick();
    noise(); dec_mem_op = 1'b1; dec_rd_we = 1'b1;
    chk_cycle("to_ma_id", 8'b0100_0000); tick();
    chk_cycle("to_ma_ex", 8'b0010_0000); tick();
    for (int i = 0; i < WL; i++) begin
      noise(); dmem_ready = 1'b0;
      chk_cycle("to_ma_wait", 8'b0001_0000); tick();
    end
    m_halt = 1'b1;
    stay_halted("to_ma", 4, 1'b1);
    do_reset();
    imem_ready = 1'b1;
    chk_cycle("abort_if", 8'b1000_0000); tick();
    dec_mem_op = 1'b0; dec_rd_we = 1'b1;
    chk_cycle("abort_id", 8'b0100_0000); tick();
    chk_cycle("abort_ex", 8'b0010_0000);
    do_reset();
    run_instr(0, 0, 0, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
